// File: rtl/aes_pkg.sv
// aes_pkg: AES field arithmetic, S-boxes, round transforms, FSM encoding and legal Nk/Nr pairs.
// State byte i lives at [127-8*i -: 8]; bytes 4c..4c+3 form column c.
package aes_pkg;
   typedef enum logic [2:0] {IDLE, SUB, SHIFT, MIX, ARK, ROUND} state_t;

   localparam int NK_128 = 4, NR_128 = 10;
   localparam int NK_192 = 6, NR_192 = 12;
   localparam int NK_256 = 8, NR_256 = 14;

   function automatic bit legal_cfg(input int nk, input int nr);
      return (nk == NK_128 && nr == NR_128) || (nk == NK_192 && nr == NR_192) ||
             (nk == NK_256 && nr == NR_256);
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         p ^= b[i] ? x : 8'h00;
         x = xtime(x);
      end
      return p;
   endfunction

   // a^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0 as AES needs
   function automatic logic [7:0] ginv(input logic [7:0] a);
      logic [7:0] r;
      r = a;
      for (int i = 0; i < 6; i++) r = gmul(gmul(r, r), a);
      return gmul(r, r);
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] a);
      logic [7:0] x, y;
      x = ginv(a);
      for (int i = 0; i < 8; i++)
         y[i] = x[i] ^ x[(i+4)%8] ^ x[(i+5)%8] ^ x[(i+6)%8] ^ x[(i+7)%8];
      return y ^ 8'h63;
   endfunction

   function automatic logic [7:0] inv_sbox(input logic [7:0] a);
      logic [7:0] x;
      for (int i = 0; i < 8; i++) x[i] = a[(i+2)%8] ^ a[(i+5)%8] ^ a[(i+7)%8];
      return ginv(x ^ 8'h05);
   endfunction

   function automatic logic [127:0] sub_bytes(input logic [127:0] s);
      logic [127:0] o;
      for (int i = 0; i < 16; i++) o[8*i +: 8] = sbox(s[8*i +: 8]);
      return o;
   endfunction

   function automatic logic [127:0] shift_rows(input logic [127:0] s);
      logic [127:0] o;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
      return o;
   endfunction

   function automatic logic [127:0] mix_columns(input logic [127:0] s);
      logic [127:0] o;
      logic [7:0]   a0, a1, a2, a3;
      for (int c = 0; c < 4; c++) begin
         {a0, a1, a2, a3} = s[127-32*c -: 32];
         o[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                              a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                              a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                              xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
      end
      return o;
   endfunction

   function automatic logic [127:0] add_round_key(input logic [127:0] s, input logic [127:0] k);
      return s ^ k;
   endfunction
endpackage

// File: rtl/aes_cipher_if.sv
// aes_cipher_if: start/busy/done handshake plus plaintext/ciphertext buses of the AES cipher.
interface aes_cipher_if;
   logic         start, busy, done;
   logic [127:0] data_in, data_out;
   modport master (output start, data_in, input busy, done, data_out);
   modport slave (input start, data_in, output busy, done, data_out);
endinterface

// File: rtl/aes_sbox.sv
// aes_sbox: combinational forward AES S-box for one byte.
module aes_sbox
   import aes_pkg::*;
(
   input  logic [7:0] a,
   output logic [7:0] y
);
   assign y = sbox(a);
endmodule

// File: rtl/aes_cipher.sv
// aes_cipher: iterative AES forward cipher over a pre-expanded key schedule w (round key 0 in MSBs).
// AES_CIPHER_FAST_ROUND_EN: one full round per cycle instead of SUB/SHIFT/MIX/ARK steps.
module aes_cipher
   import aes_pkg::*;
#(
   parameter int Nk = 4,
   parameter int Nr = 10
) (
   input  logic                  clk,
   input  logic                  rst,
   aes_cipher_if.slave           bus,
   input  logic [(Nr+1)*128-1:0] w
);
   state_t       st, st_nx;
   logic [3:0]   round, round_nx;
   logic [127:0] s, s_nx, sb, rk, rk0, fin, out_nx;
   logic         busy_nx, done_nx, last;

   if (!legal_cfg(Nk, Nr)) begin : g_bad_cfg
      $error("aes_cipher: Nk=%0d with Nr=%0d is not a legal AES configuration", Nk, Nr);
   end

   for (genvar i = 0; i < 16; i++) begin : g_sbox
      aes_sbox u_sbox (.a(s[8*i +: 8]), .y(sb[8*i +: 8]));
   end

   assign last = round == 4'(Nr);
   assign rk0  = w[(Nr+1)*128-1 -: 128];
   assign rk   = w[(Nr+1)*128-1 - 128*int'(round) -: 128];

`ifdef AES_CIPHER_FAST_ROUND_EN
   localparam state_t FIRST = ROUND, LAST_STEP = ROUND;
   assign fin = add_round_key(last ? shift_rows(sb) : mix_columns(shift_rows(sb)), rk);
`else
   localparam state_t FIRST = SUB, LAST_STEP = ARK;
   assign fin = add_round_key(s, rk);
`endif

   always_comb begin
      st_nx    = st;
      round_nx = round;
      s_nx     = s;
      out_nx   = bus.data_out;
      busy_nx  = bus.busy;
      done_nx  = 1'b0;
      case (st)
         IDLE: if (bus.start) begin
            st_nx    = FIRST;
            round_nx = 4'd1;
            s_nx     = add_round_key(bus.data_in, rk0);
            busy_nx  = 1'b1;
         end
         SUB: begin
            s_nx  = sb;
            st_nx = SHIFT;
         end
         SHIFT: begin
            s_nx  = shift_rows(s);
            st_nx = last ? ARK : MIX;
         end
         MIX: begin
            s_nx  = mix_columns(s);
            st_nx = ARK;
         end
         LAST_STEP: begin
            s_nx     = fin;
            st_nx    = last ? IDLE : FIRST;
            round_nx = last ? round : round + 4'd1;
            out_nx   = last ? fin : bus.data_out;
            busy_nx  = !last;
            done_nx  = last;
         end
         default: st_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         st           <= IDLE;
         round        <= '0;
         s            <= '0;
         bus.busy     <= 1'b0;
         bus.done     <= 1'b0;
         bus.data_out <= '0;
      end else begin
         st           <= st_nx;
         round        <= round_nx;
         s            <= s_nx;
         bus.busy     <= busy_nx;
         bus.done     <= done_nx;
         bus.data_out <= out_nx;
      end
   end
endmodule

// File: tb/tb_aes_cipher.sv
// tb_aes_cipher: directed FIPS-197 vectors, handshake, mid-run reset and inverse-cipher loopback.
module tb_aes_cipher;
   import aes_pkg::*;

`ifdef AES_CIPHER_FAST_ROUND_EN
   localparam bit FAST = 1'b1;
`else
   localparam bit FAST = 1'b0;
`endif
   localparam int LAT10 = FAST ? 10 : 39;
   localparam int LAT14 = FAST ? 14 : 55;
   localparam int P1 = FAST ? 3 : 5;
   localparam int P2 = FAST ? 7 : 20;

   localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] PT_C   = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [255:0] KEY_C3 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
   localparam logic [127:0] CT_C3  = 128'h8ea2b7ca516745bfeafc49904b496089;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic [1407:0]  w10 = '0;
   logic [1919:0]  w14 = '0;
   int             n_checks = 0;
   int             n_errors = 0;

   aes_cipher_if b10 ();
   aes_cipher_if b14 ();
   aes_cipher #(.Nk(4), .Nr(10)) dut   (.clk(clk), .rst(rst), .bus(b10), .w(w10));
   aes_cipher #(.Nk(8), .Nr(14)) dut14 (.clk(clk), .rst(rst), .bus(b14), .w(w14));

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [1919:0] expand(input logic [255:0] key, input int nk);
      logic [31:0]   wd[60];
      logic [31:0]   t;
      logic [7:0]    rc;
      logic [1919:0] o;
      rc = 8'h01;
      o  = '0;
      for (int i = 0; i < nk; i++) wd[i] = key[255-32*i -: 32];
      for (int i = nk; i < 4*(nk+7); i++) begin
         t = wd[i-1];
         if (i % nk == 0) begin
            t  = {sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0]), sbox(t[31:24])} ^ {rc, 24'h0};
            rc = xtime(rc);
         end else if (nk > 6 && i % nk == 4)
            t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])};
         wd[i] = wd[i-nk] ^ t;
      end
      for (int i = 0; i < 4*(nk+7); i++) o[1919-32*i -: 32] = wd[i];
      return o;
   endfunction

   function automatic logic [1407:0] ks10(input logic [127:0] key);
      logic [1919:0] x;
      x = expand({key, 128'h0}, 4);
      return x[1919 -: 1408];
   endfunction

   function automatic logic [127:0] inv_shift(input logic [127:0] s);
      logic [127:0] o;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            o[127-8*(4*((c+r)%4)+r) -: 8] = s[127-8*(4*c+r) -: 8];
      return o;
   endfunction

   function automatic logic [127:0] inv_sub(input logic [127:0] s);
      logic [127:0] o;
      for (int i = 0; i < 16; i++) o[8*i +: 8] = inv_sbox(s[8*i +: 8]);
      return o;
   endfunction

   function automatic logic [127:0] inv_mix(input logic [127:0] s);
      logic [127:0] o;
      logic [7:0]   a0, a1, a2, a3;
      for (int c = 0; c < 4; c++) begin
         {a0, a1, a2, a3} = s[127-32*c -: 32];
         o[127-32*c -: 32] = {gmul(a0,8'h0e) ^ gmul(a1,8'h0b) ^ gmul(a2,8'h0d) ^ gmul(a3,8'h09),
                              gmul(a0,8'h09) ^ gmul(a1,8'h0e) ^ gmul(a2,8'h0b) ^ gmul(a3,8'h0d),
                              gmul(a0,8'h0d) ^ gmul(a1,8'h09) ^ gmul(a2,8'h0e) ^ gmul(a3,8'h0b),
                              gmul(a0,8'h0b) ^ gmul(a1,8'h0d) ^ gmul(a2,8'h09) ^ gmul(a3,8'h0e)};
      end
      return o;
   endfunction

   function automatic logic [127:0] inv_cipher(input logic [127:0] ct, input logic [1407:0] w);
      logic [127:0] s;
      s = ct ^ w[127:0];
      for (int r = 9; r >= 1; r--) s = inv_mix(inv_sub(inv_shift(s)) ^ w[1407-128*r -: 128]);
      return inv_sub(inv_shift(s)) ^ w[1407 -: 128];
   endfunction

   // caller is on a falling edge; the next rising edge is the accepting one
   task automatic kick(input bit big, input logic [127:0] pt);
      b10.start   = !big;
      b14.start   = big;
      b10.data_in = pt;
      b14.data_in = pt;
      @(negedge clk);
      b10.start = 1'b0;
      b14.start = 1'b0;
   endtask

   task automatic wait_done(input bit big, output int lat, output bit moved);
      logic [127:0] held;
      held  = big ? b14.data_out : b10.data_out;
      lat   = 0;
      moved = 1'b0;
      while (!(big ? b14.done : b10.done) && lat < 200) begin
         @(negedge clk);
         lat++;
         if (!(big ? b14.done : b10.done) && (big ? b14.data_out : b10.data_out) != held) moved = 1'b1;
      end
   endtask

   task automatic run(input string tag, input bit big, input logic [127:0] pt, input logic [127:0] ct);
      int lat;
      bit moved;
      kick(big, pt);
      check({tag, " busy"}, big ? b14.busy : b10.busy, 1);
      wait_done(big, lat, moved);
      check({tag, " latency"}, lat, big ? LAT14 : LAT10);
      check({tag, " ct"}, big ? b14.data_out : b10.data_out, ct);
      check({tag, " busy at done"}, big ? b14.busy : b10.busy, 0);
      check({tag, " hold"}, moved, 0);
   endtask

   initial begin
      int          lat, ndone;
      bit          moved;
      logic [127:0] key, pt, got;
      b10.start = 1'b0; b10.data_in = '0;
      b14.start = 1'b0; b14.data_in = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check("reset busy", b10.busy, 0);
      check("reset done", b10.done, 0);
      check("reset data_out", b10.data_out, 0);
      check("reset data_out 14", b14.data_out, 0);

      w10 = ks10(KEY_B);
      run("appB", 1'b0, PT_B, CT_B);
      @(negedge clk);
      check("done one cycle", b10.done, 0);
      check("data_out held", b10.data_out, CT_B);

      w10 = ks10(KEY_C1);
      run("C1", 1'b0, PT_C, CT_C1);
      w14 = expand(KEY_C3, 8);
      run("C3", 1'b1, PT_C, CT_C3);

      // start pulses while busy must be dropped
      w10 = ks10(KEY_B);
      kick(1'b0, PT_B);
      ndone = 0; lat = 0; got = '0;
      for (int n = 1; n <= LAT10 + 5; n++) begin
         b10.start   = (n == P1 || n == P2);
         b10.data_in = b10.start ? PT_C : PT_B;
         @(negedge clk);
         if (b10.done) begin
            ndone++;
            lat = n;
            got = b10.data_out;
         end
      end
      b10.start = 1'b0;
      check("busy start done count", ndone, 1);
      check("busy start latency", lat, LAT10);
      check("busy start ct", got, CT_B);
      check("busy start hold", b10.data_out, CT_B);

      // start raised in the done cycle is taken
      kick(1'b0, PT_B);
      wait_done(1'b0, lat, moved);
      kick(1'b0, PT_B);
      wait_done(1'b0, lat, moved);
      check("done-cycle start spacing", lat + 1, FAST ? 11 : 40);
      check("done-cycle start ct", b10.data_out, CT_B);

      // reset mid-run discards the block
      kick(1'b0, PT_C);
      repeat (14) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("mid reset busy", b10.busy, 0);
      check("mid reset done", b10.done, 0);
      check("mid reset data_out", b10.data_out, 0);
      ndone = 0;
      repeat (60) begin
         @(negedge clk);
         if (b10.done) ndone++;
      end
      check("mid reset no done", ndone, 0);
      run("appB after reset", 1'b0, PT_B, CT_B);

      for (int i = 0; i < 100; i++) begin
         key = {$urandom(), $urandom(), $urandom(), $urandom()};
         pt  = {$urandom(), $urandom(), $urandom(), $urandom()};
         w10 = ks10(key);
         kick(1'b0, pt);
         wait_done(1'b0, lat, moved);
         check("loopback pt", inv_cipher(b10.data_out, w10), pt);
         check("loopback hold", moved, 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/aes_cipher.md
# aes_cipher

Iterative AES forward cipher: encrypts one 128-bit block using a pre-expanded key schedule supplied on a flat bus, with a start/busy/done handshake. It is the encrypt-side companion of the team's inverse-cipher block. It consumes the same key-schedule bus layout and the same state byte order, so the two can share one key-expansion block and be checked against each other in loopback.

## Interface
- `Nk`, default 4: key length in 32-bit words (4/6/8). Only legal with `Nr == Nk + 6`.
- `Nr`, default 10: number of rounds (10/12/14).
- `clk`  in  1: clock; all state changes on its rising edge.
- `rst`  in  1: reset, synchronous and active-high.
- `start`  in  1: request to encrypt `data_in`; sampled only in IDLE.
- `data_in`  in  128: plaintext; byte 0 at [127:120], column-major (bytes 0–3 form column 0).
- `w`  in  (Nr+1)*128: round keys; round key r at `w[(Nr+1)*128-1 - r*128 -: 128]`, so round key 0 is in the MSBs.
- `busy`  out  1: an encryption is in progress.
- `done`  out  1: one-cycle pulse; `data_out` is valid from this cycle onward.
- `data_out`  out  128: ciphertext, same byte order as `data_in`; held until the next completion.

## Operation
- States: IDLE, SUB, SHIFT, MIX, ARK. A round counter runs 1..Nr. There is one 128-bit internal state register.
- IDLE with `start=1`:
  - state ← `data_in ^ rk0`
  - round ← 1
  - busy ← 1
  - go to SUB
- IDLE with `start=0`: hold.
- SUB: state ← SubBytes(state), using the forward S-box on all 16 bytes; go to SHIFT.
- SHIFT: state ← ShiftRows(state), rotating row r left by r bytes. Go to ARK if round == Nr, else go to MIX.
- MIX: state ← MixColumns(state), using the {02,03,01,01} circulant in GF(2^8) with polynomial 0x11B; go to ARK.
- ARK: state ← state ^ rk[round].
  - If round == Nr: `data_out` ← result, done ← 1, busy ← 0, go to IDLE.
  - Otherwise: round ← round + 1, go to SUB.
- `start` while busy is ignored, not queued.
- `data_in` is sampled only on the accepting edge. `w` must stay stable from the accepting edge until `done`.
- `rst` at any time, including mid-operation:
  - state goes to IDLE, round to 0, the internal state register to 0;
  - `busy`=0, `done`=0, `data_out`=0;
  - any partial result is discarded and no `done` is produced.
- Illegal `Nr`/`Nk` pairing: elaboration-time error.

## Timing
- Reset values: `busy`=0, `done`=0, `data_out`=128'h0.
- Let `start` be accepted on edge k.
- Default build:
  - rounds 1..Nr-1 take 4 cycles each; round Nr takes 3 (no MIX);
  - `done` is registered on edge k+4·Nr−1, i.e. 39/47/55 cycles after acceptance for Nr = 10/12/14.
- `busy` is high from edge k through the cycle before `done`, and is low in the `done` cycle.
- A new `start` may be accepted in the same cycle that `done` is high (FSM is already in IDLE). Back-to-back throughput is therefore one block per 4·Nr cycles.
- `done` lasts exactly one cycle. `data_out` changes only on a `done` edge or on reset.

## Configuration
- `AES_CIPHER_FAST_ROUND_EN` defined:
  - the SUB/SHIFT/MIX/ARK sequence collapses into one ROUND state doing a full round per cycle, with MixColumns skipped when round == Nr;
  - `done` is registered on edge k+Nr (10/12/14 cycles);
  - the handshake, reset, byte-order and `data_out` holding rules are unchanged.
- Not defined: the multi-state sequence described above (smaller critical path).

## Structure
- Shared package `aes_pkg`:
  - forward and inverse S-box functions;
  - `xtime` / GF(2^8) multiply;
  - ShiftRows, MixColumns and AddRoundKey functions;
  - FSM state encoding constants;
  - legal (Nk, Nr) pair constants.
- One sub-module is natural: `aes_sbox` (8-bit combinational forward S-box), instantiated 16× for SubBytes and shared by future key expansion.

## Test plan
- FIPS-197 App. B, Nk=4/Nr=10:
  - stimulus: pt 3243f6a8885a308d313198a2e0370734, key 2b7e151628aed2a6abf7158809cf4f3c (expanded into `w`), `start` 1 cycle;
  - expected: `data_out`=3925841d02dc09fbdc118597196a0b32;
  - `done` exactly 39 cycles after acceptance (10 with `AES_CIPHER_FAST_ROUND_EN`).
- FIPS-197 C.1/C.3, Nr=10 and Nr=14:
  - stimulus: pt 00112233445566778899aabbccddeeff, key 000102…0f (C.1) and 000102…1f (C.3);
  - expected ciphertext: 69c4e0d86a7b0430d8cdb78070b4c55a (C.1) and 8ea2b7ca516745bfeafc49904b496089 (C.3).
- Handshake:
  - stimulus: second `start` pulses at 5 and 20 cycles into an encryption;
  - expected: ignored, a single `done` pulse, `data_out` equal to the first block's result;
  - stimulus: `start` in the `done` cycle;
  - expected: accepted, with the next `done` exactly 4·Nr cycles later.
- Reset mid-operation:
  - stimulus: `rst` asserted 15 cycles after `start`;
  - expected: next cycle `busy`=0, `data_out`=0, no `done`;
  - a subsequent App. B run produces the correct result.
- Loopback:
  - stimulus: 100 random pt/key pairs through `aes_cipher`, then the inverse-cipher block with the same `w`;
  - expected: original plaintext recovered every time;
  - `data_out` stable between `done` pulses.
